// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared defaults, read-tag type and index helper for the SRAM port arbiter
package sram_port_arbiter_pkg;
   localparam int AW_DEF    = 18;
   localparam int DW_DEF    = 16;
   localparam int NREQ_DEF  = 3;
   localparam int IDX_W     = $clog2(NREQ_DEF);
   localparam int IDX_MAX_W = 3;

   typedef struct packed {
      logic                 valid;
      logic [IDX_MAX_W-1:0] idx;
   } rd_tag_t;

   function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [7:0] oh);
      logic [IDX_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) r = IDX_MAX_W'(i);
      end
      return r;
   endfunction
endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// rtl/sram_port_arbiter_rr_arbiter.sv - round-robin arbiter, combinational grant from req and registered pointer
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] next_ptr;
   logic          found;
   int            k;

   always_comb begin
      gnt      = '0;
      next_ptr = ptr;
      found    = 1'b0;
      k        = 0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         if (en && !found && req[k]) begin
            gnt[k]   = 1'b1;
            found    = 1'b1;
            next_ptr = (k == N - 1) ? '0 : PW'(k + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) ptr <= '0;
      else        ptr <= next_ptr;
   end
endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - independent read/write SRAM port arbiter; SRAM_ARB_VGA_PRIO_EN gives requester 0 read priority
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int NREQ   = NREQ_DEF,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    rd_req,
   input  logic [NREQ*AW-1:0] rd_addr,
   output logic [NREQ-1:0]    rd_gnt,
   output logic [NREQ-1:0]    rd_valid,
   output logic [DW-1:0]      rd_data,
   output logic [AW-1:0]      sram_raddr,
   input  logic [DW-1:0]      sram_rdata,
   input  logic [NREQ-1:0]    wr_req,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]    wr_gnt,
   output logic [AW-1:0]      sram_waddr,
   output logic [DW-1:0]      sram_wdata,
   output logic               sram_wr_enable
);
   logic [NREQ-1:0]      rr_rd_req;
   logic [NREQ-1:0]      rr_rd_gnt;
   logic                 rr_rd_en;
   logic [IDX_MAX_W-1:0] rd_idx;
   rd_tag_t              pipe [RD_LAT];

`ifdef SRAM_ARB_VGA_PRIO_EN
   // VGA fetcher wins outright; the rr pointer only moves on grants among 1..NREQ-1
   assign rr_rd_req = {rd_req[NREQ-1:1], 1'b0};
   assign rr_rd_en  = reset & ~rd_req[0];
   assign rd_gnt    = (reset & rd_req[0]) ? NREQ'(1) : rr_rd_gnt;
`else
   assign rr_rd_req = rd_req;
   assign rr_rd_en  = reset;
   assign rd_gnt    = rr_rd_gnt;
`endif

   rr_arbiter #(.N(NREQ)) u_rd_arb (
      .clk   (clk),
      .reset (reset),
      .en    (rr_rd_en),
      .req   (rr_rd_req),
      .gnt   (rr_rd_gnt)
   );

   rr_arbiter #(.N(NREQ)) u_wr_arb (
      .clk   (clk),
      .reset (reset),
      .en    (reset),
      .req   (wr_req),
      .gnt   (wr_gnt)
   );

   assign rd_idx = onehot_to_idx(8'(rd_gnt));

   always_comb begin
      sram_raddr = '0;
      sram_waddr = '0;
      sram_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (rd_gnt[i]) sram_raddr = rd_addr[i*AW +: AW];
         if (wr_gnt[i]) begin
            sram_waddr = wr_addr[i*AW +: AW];
            sram_wdata = wr_data[i*DW +: DW];
         end
      end
   end

   assign sram_wr_enable = |wr_gnt;

   // The tag travels alongside the SRAM access so the strobe lines up with sram_rdata
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < RD_LAT; s++) pipe[s] <= '0;
      end else begin
         pipe[0] <= {|rd_gnt, rd_idx};
         for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
      end
   end

   always_comb begin
      rd_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         rd_valid[i] = pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].idx == IDX_MAX_W'(i));
      end
   end

   assign rd_data = (|rd_valid) ? sram_rdata : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter at read latencies 1 and 2
module tb_sram_port_arbiter;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam int N  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [N-1:0]    rd_req, wr_req;
   logic [N*AW-1:0] rd_addr, wr_addr;
   logic [N*DW-1:0] wr_data;

   logic [N-1:0]  rd_gnt1, rd_valid1, wr_gnt1, rd_gnt2, rd_valid2, wr_gnt2;
   logic [DW-1:0] rd_data1, rd_data2, sram_rdata1, sram_rdata2, sram_wdata1, sram_wdata2;
   logic [AW-1:0] sram_raddr1, sram_raddr2, sram_waddr1, sram_waddr2;
   logic          sram_wr_enable1, sram_wr_enable2;

   sram_port_arbiter #(.AW(AW), .DW(DW), .NREQ(N), .RD_LAT(1)) dut1 (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1), .rd_valid(rd_valid1), .rd_data(rd_data1),
      .sram_raddr(sram_raddr1), .sram_rdata(sram_rdata1),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt1),
      .sram_waddr(sram_waddr1), .sram_wdata(sram_wdata1), .sram_wr_enable(sram_wr_enable1)
   );

   sram_port_arbiter #(.AW(AW), .DW(DW), .NREQ(N), .RD_LAT(2)) dut2 (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt2), .rd_valid(rd_valid2), .rd_data(rd_data2),
      .sram_raddr(sram_raddr2), .sram_rdata(sram_rdata2),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt2),
      .sram_waddr(sram_waddr2), .sram_wdata(sram_wdata2), .sram_wr_enable(sram_wr_enable2)
   );

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hBFEF;
   endfunction

   logic [AW-1:0] a1_q, a2_q1, a2_q2;
   always @(posedge clk) begin
      a1_q  <= sram_raddr1;
      a2_q1 <= sram_raddr2;
      a2_q2 <= a2_q1;
   end
   assign sram_rdata1 = mem_word(a1_q);
   assign sram_rdata2 = mem_word(a2_q2);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return N'(1) << ((p + i) % N);
      end
      return '0;
   endfunction

   function automatic int oh2i(input logic [N-1:0] oh);
      for (int i = 0; i < N; i++) if (oh[i]) return i;
      return 0;
   endfunction

   typedef struct {
      int            due;
      logic [N-1:0]  oh;
      logic [DW-1:0] d;
   } rd_exp_t;

   rd_exp_t q1[$];
   rd_exp_t q2[$];
   int cyc = 0;
   int m_rptr = 0;
   int m_wptr = 0;

   always @(negedge clk) begin : mon
      logic [N-1:0]  er, ew;
      logic [AW-1:0] era, ewa;
      logic [DW-1:0] ewd;
      bit            vga;
      cyc++;
      er  = '0;
      ew  = '0;
      vga = 1'b0;
      if (reset) begin
`ifdef SRAM_ARB_VGA_PRIO_EN
         if (rd_req[0]) begin
            er  = 3'b001;
            vga = 1'b1;
         end else begin
            er = rr_pick(rd_req & 3'b110, m_rptr);
         end
`else
         er = rr_pick(rd_req, m_rptr);
`endif
         ew = rr_pick(wr_req, m_wptr);
      end
      era = (er == 0) ? '0 : rd_addr[oh2i(er)*AW +: AW];
      ewa = (ew == 0) ? '0 : wr_addr[oh2i(ew)*AW +: AW];
      ewd = (ew == 0) ? '0 : wr_data[oh2i(ew)*DW +: DW];

      chk("rd_gnt1", rd_gnt1, er);
      chk("rd_gnt2", rd_gnt2, er);
      chk("sram_raddr1", sram_raddr1, era);
      chk("sram_raddr2", sram_raddr2, era);
      chk("wr_gnt1", wr_gnt1, ew);
      chk("wr_gnt2", wr_gnt2, ew);
      chk("sram_wr_enable1", sram_wr_enable1, (ew != 0));
      chk("sram_waddr1", sram_waddr1, ewa);
      chk("sram_wdata1", sram_wdata1, ewd);
      chk("sram_wr_enable2", sram_wr_enable2, (ew != 0));

      if (q1.size() > 0 && q1[0].due == cyc) begin
         chk("rd_valid1", rd_valid1, q1[0].oh);
         chk("rd_data1", rd_data1, q1[0].d);
         void'(q1.pop_front());
      end else begin
         chk("rd_valid1_idle", rd_valid1, 0);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
         chk("rd_valid2", rd_valid2, q2[0].oh);
         chk("rd_data2", rd_data2, q2[0].d);
         void'(q2.pop_front());
      end else begin
         chk("rd_valid2_idle", rd_valid2, 0);
      end

      if (!reset) begin
         m_rptr = 0;
         m_wptr = 0;
         q1.delete();
         q2.delete();
      end else begin
         if (er != 0) begin
            if (!vga) m_rptr = (oh2i(er) + 1) % N;
            q1.push_back('{cyc + 1, er, mem_word(era)});
            q2.push_back('{cyc + 2, er, mem_word(era)});
         end
         if (ew != 0) m_wptr = (oh2i(ew) + 1) % N;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [N-1:0] ord [9];
   int seen;

   initial begin
      reset   = 1'b0;
      rd_req  = '0;
      wr_req  = '0;
      rd_addr = '0;
      wr_addr = '0;
      wr_data = '0;
`ifdef SRAM_ARB_VGA_PRIO_EN
      for (int i = 0; i < 9; i++) ord[i] = 3'b001;
`else
      for (int i = 0; i < 9; i++) ord[i] = 3'b001 << (i % 3);
`endif
      repeat (3) step();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_rd_gnt", rd_gnt1, 0);
      chk("rst_wr_gnt", wr_gnt1, 0);
      chk("rst_rd_valid", rd_valid1, 0);
      chk("rst_wr_en", sram_wr_enable1, 0);
      chk("rst_raddr", sram_raddr1, 0);
      chk("rst_waddr", sram_waddr1, 0);
      chk("rst_wdata", sram_wdata1, 0);

      step();
      rd_req = 3'b010;
      rd_addr[1*AW +: AW] = 18'h00100;
      @(negedge clk);
      chk("single_gnt", rd_gnt1, 3'b010);
      chk("single_raddr", sram_raddr1, 18'h00100);
      step();
      rd_req = '0;
      @(negedge clk);
      chk("single_valid", rd_valid1, 3'b010);
      chk("single_data", rd_data1, 16'hBEEF);

      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      rd_addr = {18'h03333, 18'h00222, 18'h00011};
      rd_req  = 3'b111;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk($sformatf("burst_gnt%0d", i), rd_gnt1, ord[i]);
         step();
      end
      rd_req = 3'b110;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("alt_gnt%0d", i), rd_gnt1, (i % 2 == 0) ? 3'b010 : 3'b100);
         step();
      end
      rd_req = '0;
      step();

      rd_req = 3'b100;
      wr_req = 3'b100;
      wr_addr[2*AW +: AW] = 18'h3FFFF;
      wr_data[2*DW +: DW] = 16'h1234;
      @(negedge clk);
      chk("dual_rd_gnt", rd_gnt1, 3'b100);
      chk("dual_wr_gnt", wr_gnt1, 3'b100);
      chk("dual_wr_en", sram_wr_enable1, 1);
      chk("dual_waddr", sram_waddr1, 18'h3FFFF);
      chk("dual_wdata", sram_wdata1, 16'h1234);
      step();
      rd_req = 3'b011;
      wr_req = '0;
      @(negedge clk);
      chk("wrap_gnt", rd_gnt1, 3'b001);
      step();
      rd_req = 3'b100;
      @(negedge clk);
      chk("rstmid_gnt", rd_gnt2, 3'b100);
      step();
      rd_req = '0;
      reset  = 1'b0;
      @(negedge clk);
      chk("rstmid_gnt_forced", rd_gnt2, 0);
      step();
      reset = 1'b1;
      seen  = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rd_valid2 != 0) seen++;
         step();
      end
      chk("rstmid_no_valid", seen, 0);
      rd_req = 3'b110;
      wr_req = 3'b110;
      @(negedge clk);
      chk("rstmid_next_rd", rd_gnt2, 3'b010);
      chk("rstmid_next_wr", wr_gnt2, 3'b010);
      step();

      for (int i = 0; i < 400; i++) begin
         rd_req  = N'($urandom_range(0, 7));
         wr_req  = N'($urandom_range(0, 7));
         rd_addr = (N*AW)'({$urandom(), $urandom()});
         wr_addr = (N*AW)'({$urandom(), $urandom()});
         wr_data = (N*DW)'({$urandom(), $urandom()});
         reset   = ($urandom_range(0, 49) != 0);
         step();
      end
      reset  = 1'b1;
      rd_req = '0;
      wr_req = '0;
      repeat (4) step();
      chk("drain_q1", q1.size(), 0);
      chk("drain_q2", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter AW, default 18, SRAM address width.
REQ-002 Parameter DW, default 16, SRAM data width.
REQ-003 Parameter NREQ, default 3, number of requesters per port; legal range 2..8.
REQ-004 Parameter RD_LAT, default 1, SRAM read latency in cycles, from raddr to rdata; legal range 1..4.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 rd_req  input  NREQ  per-requester read request.
REQ-008 rd_addr  input  NREQ*AW  packed read addresses; requester i uses bits [i*AW +: AW].
REQ-009 rd_gnt  output  NREQ  one-hot read grant.
REQ-010 rd_valid  output  NREQ  one-hot strobe that marks rd_data as valid for requester i.
REQ-011 rd_data  output  DW  read data broadcast to all requesters.
REQ-012 sram_raddr  output  AW  SRAM read-port address.
REQ-013 sram_rdata  input  DW  SRAM read-port data.
REQ-014 wr_req  input  NREQ  per-requester write request.
REQ-015 wr_addr  input  NREQ*AW  packed write addresses.
REQ-016 wr_data  input  NREQ*DW  packed write data.
REQ-017 wr_gnt  output  NREQ  one-hot write grant.
REQ-018 sram_waddr  output  AW  SRAM write address.
REQ-019 sram_wdata  output  DW  SRAM write data.
REQ-020 sram_wr_enable  output  1  SRAM write strobe.

Function
REQ-021 The read and write ports SHALL be arbitrated independently in the same cycle; neither port stalls the other.
REQ-022 Grants SHALL be combinational from the request vector and the registered priority pointer; at most one bit of each grant vector is high per cycle.
REQ-023 A requester SHALL hold its req, addr and data stable until it sees gnt; a cycle with req high and gnt high completes one transfer.
REQ-024 Round-robin: the search starts at pointer p and wraps from NREQ-1 to 0; after a grant to index k, p becomes (k+1) mod NREQ; with no grant, p is unchanged.
REQ-025 Read: in the grant cycle T, sram_raddr SHALL equal the winner's address; with no grant, sram_raddr is 0.
REQ-026 rd_valid[k] SHALL pulse in cycle T+RD_LAT and rd_data = sram_rdata in that cycle; this is realised by a RD_LAT-deep pipeline of {valid, index}.
REQ-027 Back-to-back read grants SHALL be supported every cycle; up to RD_LAT reads are in flight.
REQ-028 Write: in the grant cycle, sram_wr_enable=1 and sram_waddr/sram_wdata are the winner's values; with no grant, all three are 0.
REQ-029 If the same requester asserts rd_req and wr_req in one cycle, both SHALL be granted.
REQ-030 A requester that drops req before gnt SHALL be ignored; no transfer is recorded for it.
REQ-031 With N requesters continuously active, each SHALL be granted at least once per N grant cycles (no starvation), except as in REQ-035.

Reset
REQ-032 While reset=0 at a clock edge: both pointers go to 0, the read pipeline is cleared, and outputs in the following cycle are rd_valid=0, rd_gnt=0, wr_gnt=0, sram_wr_enable=0, sram_raddr=0, sram_waddr=0, sram_wdata=0.
REQ-033 Grants SHALL be forced to 0 during any reset cycle.
REQ-034 A reset that arrives mid-operation SHALL discard in-flight reads; no rd_valid is emitted for them after reset.

Configuration
REQ-035 Macro SRAM_ARB_VGA_PRIO_EN defined: requester 0, the VGA frame fetcher, has absolute priority on the read port, and round-robin applies among indices 1..NREQ-1 only. The write port is unaffected.
REQ-036 Macro SRAM_ARB_VGA_PRIO_EN undefined: both ports use pure round-robin over all NREQ requesters.

Structure
REQ-037 A shared package/include file SHALL hold the default AW, DW and NREQ values and the index-width constant $clog2(NREQ).
REQ-038 A single sub-module rr_arbiter (req vector in, one-hot gnt out, pointer register, enable input) SHALL be instantiated once per port.

Verification
REQ-039 Single read: rd_req=3'b010, addr 18'h00100, RD_LAT=1, SRAM word 16'hBEEF -> rd_gnt=3'b010 in cycle T; rd_valid=3'b010 and rd_data=16'hBEEF in cycle T+1.
REQ-040 All three requesters read continuously for 9 cycles, macro undefined -> grant order 0,1,2,0,1,2,0,1,2; rd_valid follows the same order one cycle later.
REQ-041 Same stimulus, macro defined -> requester 0 is granted in all 9 cycles; after rd_req[0] drops, grants alternate 1,2,1,2.
REQ-042 Requester 2 asserts wr_req and rd_req together, wr addr 18'h3FFFF, data 16'h1234 -> both granted in the same cycle, sram_wr_enable=1, sram_waddr=18'h3FFFF.
REQ-043 Reset (reset=0) in the cycle after a read grant with RD_LAT=2 -> no rd_valid is ever emitted for that read; both pointers are 0 afterwards; the next grant goes to the lowest requesting index.
REQ-044 Pointer wrap: last grant to index 2, then rd_req=3'b011 -> grant to index 0.
